easyaxi_slv_wr: RTL
===================

// Module: easyaxi_slv_wr
// PURPOSE
//  AXI write-side slave (AW/W/B channels); counterpart to the read master/slave pair on AR/R.
//  Accepts one write burst at a time, writes beats into a local word array, returns one B response.
//  Sits beside the read slave; the top links it to the write master in the same way as AR/R.
// PARAMETERS
//  ID_W     4   AWID/BID width
//  ADDR_W   16  AWADDR width (byte address)
//  DATA_W   32  WDATA width; STRB_W = DATA_W/8
//  LEN_W    8   AWLEN width
//  MEM_DEPTH 64 words in local array; index = addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         async reset, active low
//  enable       in   1         when 0, no new AW is accepted; a burst in progress completes
//  axi_slv_awvalid in  1       AW valid
//  axi_slv_awready out 1       AW ready
//  axi_slv_awid    in  ID_W    write ID
//  axi_slv_awaddr  in  ADDR_W  start byte address
//  axi_slv_awlen   in  LEN_W   beats-1
//  axi_slv_awsize  in  3       log2 bytes/beat
//  axi_slv_awburst in  2       0=FIXED 1=INCR 2=WRAP 3=rsvd
//  axi_slv_wvalid  in  1       W valid
//  axi_slv_wready  out 1       W ready
//  axi_slv_wdata   in  DATA_W  write data
//  axi_slv_wstrb   in  STRB_W  byte lane enables
//  axi_slv_wlast   in  1       last beat marker
//  axi_slv_bvalid  out 1       B valid
//  axi_slv_bready  in  1       B ready
//  axi_slv_bid     out ID_W    = latched awid
//  axi_slv_bresp   out 2       0=OKAY 2=SLVERR
// BEHAVIOUR
//  Reset: state IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=0; beat cnt, addr, err=0; array cleared.
//  FSM IDLE->DATA->RESP->IDLE. awready=(IDLE&&enable); wready=(DATA); bvalid=(RESP). All registered.
//  IDLE: on awvalid&&awready latch id/addr/len/size/burst, cnt=0, err=0; go DATA next cycle.
//   err preset 1 if awburst is WRAP/rsvd or awsize > log2(STRB_W).
//  DATA: each wvalid&&wready = one beat. Write strobed bytes at current word index unless err or index
//   >= MEM_DEPTH (out of range: drop write, set err). cnt increments (LEN_W+1 bits, no wrap).
//   Next addr: INCR addr+(1<<size), FIXED unchanged. Burst ends on the first of: wlast beat, or
//   beat cnt==len beat with wlast=0. Early wlast (cnt<len) -> err. Missing wlast on final beat -> err;
//   subsequent beats are accepted and discarded until wlast, then go RESP.
//  RESP: bvalid=1, bresp=err?SLVERR:OKAY, held stable until bready; on bvalid&&bready go IDLE;
//   awready rises the following cycle (no AW/B overlap; 1 idle cycle between bursts minimum).
//  Latency: AW handshake -> wready high next cycle; last W beat -> bvalid next cycle.
//  Never asserts awready and wready in the same cycle; W beats arriving before AW are stalled.
//  enable deasserted mid-burst: no effect until back in IDLE.
//  rst_n low at any time: immediate return to IDLE, outputs to reset values, partial burst lost.
// TESTING
//  1 INCR awid=3 addr=0x10 len=3 size=2, data 1..4 wstrb=F -> words 4..7 = 1..4, bid=3 bresp=OKAY.
//  2 FIXED addr=0x08 len=2 data A,B,C -> word 2 = C only, OKAY; wstrb=0x3 on last -> upper 2 bytes keep B.
//  3 WRAP len=1 -> 2 beats accepted, array unchanged, bresp=SLVERR.
//  4 len=3 with wlast on beat 2 -> bvalid after beat 2, SLVERR; len=1 wlast on beat 4 -> 4 beats, SLVERR.
//  5 addr=0xFC len=3 (MEM_DEPTH=64) -> word 63 written, remaining beats dropped, SLVERR.
//  6 bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready 0; rst_n pulse mid-DATA -> all outs 0.

Source files
------------

// File: rtl/easyaxi_slv_wr.sv
// AXI write-side slave: accepts one AW/W burst at a time into a local word array
// and answers with a single B response.
module easyaxi_slv_wr #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MEM_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                axi_slv_awvalid,
  output logic                axi_slv_awready,
  input  logic [ID_W-1:0]     axi_slv_awid,
  input  logic [ADDR_W-1:0]   axi_slv_awaddr,
  input  logic [LEN_W-1:0]    axi_slv_awlen,
  input  logic [2:0]          axi_slv_awsize,
  input  logic [1:0]          axi_slv_awburst,
  input  logic                axi_slv_wvalid,
  output logic                axi_slv_wready,
  input  logic [DATA_W-1:0]   axi_slv_wdata,
  input  logic [DATA_W/8-1:0] axi_slv_wstrb,
  input  logic                axi_slv_wlast,
  output logic                axi_slv_bvalid,
  input  logic                axi_slv_bready,
  output logic [ID_W-1:0]     axi_slv_bid,
  output logic [1:0]          axi_slv_bresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [2:0]        size_reg, size_next;
  logic [1:0]        burst_reg, burst_next;
  logic [LEN_W:0]    cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              awready_reg, awready_next;
  logic              wready_reg, wready_next;
  logic              bvalid_reg, bvalid_next;
  logic [1:0]        bresp_reg, bresp_next;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              aw_fire, w_fire, in_range, beat_active, beat_wr;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  mem_idx;

  assign aw_fire     = axi_slv_awvalid && awready_reg;
  assign w_fire      = axi_slv_wvalid && wready_reg;
  assign word_addr   = addr_reg >> OFF_W;
  assign in_range    = word_addr < DEPTH_A;
  assign mem_idx     = word_addr[IDX_W-1:0];
  // Beats past the announced length are swallowed while waiting for wlast.
  assign beat_active = cnt_reg <= {1'b0, len_reg};
  assign beat_wr     = w_fire && beat_active && !err_reg && in_range;

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    size_next  = size_reg;
    burst_next = burst_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    bresp_next = bresp_reg;
    case (state_reg)
      IDLE: begin
        if (aw_fire) begin
          id_next    = axi_slv_awid;
          addr_next  = axi_slv_awaddr;
          len_next   = axi_slv_awlen;
          size_next  = axi_slv_awsize;
          burst_next = axi_slv_awburst;
          cnt_next   = '0;
          err_next   = axi_slv_awburst[1] || (axi_slv_awsize > 3'(OFF_W));
          state_next = DATA;
        end
      end
      DATA: begin
        if (w_fire) begin
          if (beat_active) begin
            if (!err_reg && !in_range) err_next = 1'b1;
            if (axi_slv_wlast && (cnt_reg < {1'b0, len_reg})) err_next = 1'b1;
            if (!axi_slv_wlast && (cnt_reg == {1'b0, len_reg})) err_next = 1'b1;
          end
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
          if (burst_reg == 2'd1) addr_next = addr_reg + (ADDR_W'(1) << size_reg);
          if (axi_slv_wlast) begin
            bresp_next = err_next ? 2'd2 : 2'd0;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (bvalid_reg && axi_slv_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // awready waits one cycle in IDLE after a response so AW never overlaps B.
    awready_next = (state_reg == IDLE) && (state_next == IDLE) && enable;
    wready_next  = (state_next == DATA);
    bvalid_next  = (state_next == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      id_reg      <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      size_reg    <= size_next;
      burst_reg   <= burst_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (beat_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_slv_wstrb[b]) mem[mem_idx][8*b +: 8] <= axi_slv_wdata[8*b +: 8];
      end
    end
  end

  assign axi_slv_awready = awready_reg;
  assign axi_slv_wready  = wready_reg;
  assign axi_slv_bvalid  = bvalid_reg;
  assign axi_slv_bid     = id_reg;
  assign axi_slv_bresp   = bresp_reg;

endmodule
